trig_lut_scheduler: RTL and testbench

TRIG_LUT_SCHEDULER -- requirements
Module: trig_lut_scheduler

---
 rtl/trig_lut_scheduler_pkg.sv | 29 ++
 rtl/trig_angle_reduce.sv | 37 +++
 rtl/trig_lut_scheduler.sv | 153 +++++++++++++++
 tb/tb_trig_lut_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/trig_lut_scheduler_pkg.sv
// Shared constants, state encoding and small helpers for the trig LUT scheduler.
package trig_lut_scheduler_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ANGLE_LIMIT    = 360;
  localparam int QUAD_SPAN      = 90;
  localparam int SIGN_BIT       = 63;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Fold a quadrant/remainder pair onto the first-quadrant cosine table index.
  function automatic logic [6:0] lut_index(input logic func, input logic [1:0] quad,
                                           input logic [6:0] rem);
    logic use_rem;
    use_rem = func ? quad[0] : ~quad[0];
    return use_rem ? rem : (7'(QUAD_SPAN) - rem);
  endfunction

  // Sign of the final result: cosine negative in q1/q2, sine negative in q2/q3.
  function automatic logic negate_result(input logic func, input logic [1:0] quad);
    return func ? quad[1] : (quad[1] ^ quad[0]);
  endfunction

endpackage

// File: rtl/trig_angle_reduce.sv
// Splits a whole-degree angle into quadrant and in-quadrant remainder.
module trig_angle_reduce
  import trig_lut_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] angle,
  output logic [1:0]            quadrant,
  output logic [6:0]            remainder,
  output logic                  range_err
);

  localparam logic [8:0] SPAN1 = 9'(QUAD_SPAN);
  localparam logic [8:0] SPAN2 = 9'(2 * QUAD_SPAN);
  localparam logic [8:0] SPAN3 = 9'(3 * QUAD_SPAN);

  logic [8:0] angle9;

  // Divide by 90 with a compare/subtract chain on the low nine bits.
  always_comb begin
    range_err = (angle >= DATA_WIDTH'(ANGLE_LIMIT));
    angle9    = angle[8:0];
    quadrant  = 2'd0;
    remainder = angle9[6:0];
    if (angle9 >= SPAN3) begin
      quadrant  = 2'd3;
      remainder = 7'(angle9 - SPAN3);
    end else if (angle9 >= SPAN2) begin
      quadrant  = 2'd2;
      remainder = 7'(angle9 - SPAN2);
    end else if (angle9 >= SPAN1) begin
      quadrant  = 2'd1;
      remainder = 7'(angle9 - SPAN1);
    end
  end

endmodule

// File: rtl/trig_lut_scheduler.sv
// Arbitrates two requesters onto one shared cosine LUT and returns signed doubles.
module trig_lut_scheduler
  import trig_lut_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int LUT_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_func,
  input  logic [DATA_WIDTH-1:0]   req_angle0,
  input  logic [DATA_WIDTH-1:0]   req_angle1,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic                    rsp_err,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    lut_en,
  output logic [1:0]              lut_quadrant,
  output logic [DATA_WIDTH-1:0]   lut_angle,
  input  logic [2*DATA_WIDTH-1:0] lut_data
);

  localparam int RW = 2 * DATA_WIDTH;

  state_e          state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic            id_q, id_d;
  logic            func_q, func_d;
  logic [1:0]      quad_q, quad_d;
  logic [6:0]      rem_q, rem_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;
  logic [RW-1:0]   rsp_data_q, rsp_data_d;

  logic                  grant;
  logic [DATA_WIDTH-1:0] sel_angle;
  logic [1:0]            red_quad;
  logic [6:0]            red_rem;
  logic                  red_err;
  logic [6:0]            lut_idx;
  logic                  negate;

  trig_angle_reduce #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_reduce (
    .angle    (sel_angle),
    .quadrant (red_quad),
    .remainder(red_rem),
    .range_err(red_err)
  );

  assign sel_angle    = grant ? req_angle1 : req_angle0;
  assign lut_idx      = lut_index(func_q, quad_q, rem_q);
  assign negate       = negate_result(func_q, quad_q);
  assign lut_quadrant = 2'b00;
  assign rsp_id       = id_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_data     = rsp_data_q;

  // Next-state, arbitration and output decode for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    func_d     = func_q;
    quad_d     = quad_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    req_ready  = 2'b00;
    rsp_valid  = 1'b0;
    lut_en     = 1'b0;
    lut_angle  = '0;
    grant      = (&req_valid) ? rr_ptr_q : req_valid[1];
    case (state_q)
      ST_IDLE: begin
        if ((|req_valid) && !reset) begin
          req_ready[grant] = 1'b1;
          id_d     = grant;
          func_d   = req_func[grant];
          rr_ptr_d = ~grant;
          if (red_err) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = ST_RESP;
          end else begin
            rsp_err_d = 1'b0;
            quad_d    = red_quad;
            rem_d     = red_rem;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        lut_en    = 1'b1;
        lut_angle = DATA_WIDTH'(lut_idx);
        cnt_d     = 3'(LUT_LATENCY);
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q <= 3'd1) begin
          cnt_d      = 3'd0;
          rsp_data_d = lut_data;
          if (lut_data[SIGN_BIT-1:0] == '0) begin
            rsp_data_d[SIGN_BIT] = 1'b0;
          end else begin
            rsp_data_d[SIGN_BIT] = lut_data[SIGN_BIT] ^ negate;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 1'b0;
      id_q       <= 1'b0;
      func_q     <= 1'b0;
      quad_q     <= 2'd0;
      rem_q      <= 7'd0;
      cnt_q      <= 3'd0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      func_q     <= func_d;
      quad_q     <= quad_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_trig_lut_scheduler.sv
// Directed bench for trig_lut_scheduler with a one-cycle cosine LUT model.
module tb_trig_lut_scheduler;

  localparam int DW  = 32;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [1:0]    req_func = 2'b00;
  logic [DW-1:0] req_angle0 = '0;
  logic [DW-1:0] req_angle1 = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_id;
  logic          rsp_err;
  logic [63:0]   rsp_data;
  logic          lut_en;
  logic [1:0]    lut_quadrant;
  logic [DW-1:0] lut_angle;
  logic [63:0]   lut_data = '0;

  int checks = 0;
  int errors = 0;

  trig_lut_scheduler #(.DATA_WIDTH(DW), .LUT_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_angle0(req_angle0), .req_angle1(req_angle1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .rsp_data(rsp_data),
    .lut_en(lut_en), .lut_quadrant(lut_quadrant), .lut_angle(lut_angle),
    .lut_data(lut_data)
  );

  always #5 clk = ~clk;

  // Known cosine values; any other index returns a tagged marker pattern.
  function automatic logic [63:0] cosTable(input logic [DW-1:0] idx);
    case (idx)
      32'd0:   return 64'h3FF0_0000_0000_0000;
      32'd30:  return 64'h3FEB_B67A_E858_4CAA;
      32'd60:  return 64'h3FE0_0000_0000_0000;
      32'd90:  return 64'h0000_0000_0000_0000;
      default: return 64'h4000_0000_0000_0000 | {32'h0, idx};
    endcase
  endfunction

  // Registered LUT: sampled on lut_en, value held until the next access.
  always @(posedge clk) begin
    if (lut_en) lut_data <= cosTable(lut_angle);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " req_ready"}, 64'(req_ready), 64'd0);
    checkOutput({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    checkOutput({tag, " rsp_id"}, 64'(rsp_id), 64'd0);
    checkOutput({tag, " rsp_err"}, 64'(rsp_err), 64'd0);
    checkOutput({tag, " rsp_data"}, rsp_data, 64'd0);
    checkOutput({tag, " lut_en"}, 64'(lut_en), 64'd0);
    checkOutput({tag, " lut_quadrant"}, 64'(lut_quadrant), 64'd0);
    checkOutput({tag, " lut_angle"}, 64'(lut_angle), 64'd0);
  endtask

  // Runs one transaction; called just after a negedge, returns just after one.
  task automatic applyStimulus(input logic [1:0] raise, input int expId, input int expIdx,
                               input logic expErr, input logic [63:0] expData,
                               input int stall, input bit poke);
    int n;
    int lutCount;
    logic [DW-1:0] lutAng;
    logic [1:0] expReady;
    expReady = 2'b01 << expId;
    req_valid = req_valid | raise;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("req_ready grant", 64'(req_ready), 64'(expReady));
    @(posedge clk);
    #1;
    req_valid[expId] = 1'b0;
    n = 0;
    lutCount = 0;
    lutAng = '0;
    do begin
      @(negedge clk);
      n++;
      if (lut_en) begin
        lutCount++;
        lutAng = lut_angle;
        checkOutput("lut_quadrant", 64'(lut_quadrant), 64'd0);
      end
    end while (!rsp_valid && n < 20);
    checkOutput("rsp latency", 64'(n), expErr ? 64'd1 : 64'(LAT + 2));
    checkOutput("lut_en count", 64'(lutCount), expErr ? 64'd0 : 64'd1);
    if (!expErr) checkOutput("lut_angle", 64'(lutAng), 64'(expIdx));
    for (int k = 0; k < stall; k++) begin
      if (poke && k == 0) begin
        req_valid[1] = 1'b1;
        #1;
        checkOutput("ready while busy", 64'(req_ready), 64'd0);
      end
      if (poke && k == 1) req_valid[1] = 1'b0;
      checkOutput("stall rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("stall rsp_data", rsp_data, expData);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    checkOutput("rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("rsp_id", 64'(rsp_id), 64'(expId));
    checkOutput("rsp_err", 64'(rsp_err), 64'(expErr));
    checkOutput("rsp_data", rsp_data, expData);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("rsp_valid drop", 64'(rsp_valid), 64'd0);
  endtask

  typedef struct {
    int          id;
    logic        func;
    logic [31:0] angle;
    int          idx;
    logic        err;
    logic [63:0] data;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{0, 1'b0, 32'd0,          0,  1'b0, 64'h3FF0_0000_0000_0000};
    vecs[1]  = '{1, 1'b1, 32'd210,        60, 1'b0, 64'hBFE0_0000_0000_0000};
    vecs[2]  = '{0, 1'b0, 32'd90,         90, 1'b0, 64'h0000_0000_0000_0000};
    vecs[3]  = '{1, 1'b1, 32'd180,        90, 1'b0, 64'h0000_0000_0000_0000};
    vecs[4]  = '{0, 1'b0, 32'd180,        0,  1'b0, 64'hBFF0_0000_0000_0000};
    vecs[5]  = '{1, 1'b1, 32'd270,        0,  1'b0, 64'hBFF0_0000_0000_0000};
    vecs[6]  = '{0, 1'b1, 32'd90,         0,  1'b0, 64'h3FF0_0000_0000_0000};
    vecs[7]  = '{1, 1'b0, 32'd300,        60, 1'b0, 64'h3FE0_0000_0000_0000};
    vecs[8]  = '{0, 1'b1, 32'd30,         60, 1'b0, 64'h3FE0_0000_0000_0000};
    vecs[9]  = '{1, 1'b0, 32'd330,        30, 1'b0, 64'h3FEB_B67A_E858_4CAA};
    vecs[10] = '{0, 1'b0, 32'd360,        0,  1'b1, 64'h0000_0000_0000_0000};
    vecs[11] = '{1, 1'b1, 32'd359,        89, 1'b0, 64'hC000_0000_0000_0059};
    vecs[12] = '{0, 1'b0, 32'd4000000000, 0,  1'b1, 64'h0000_0000_0000_0000};
    vecs[13] = '{1, 1'b0, 32'd120,        60, 1'b0, 64'hBFE0_0000_0000_0000};

    // Reset with a pending request: nothing may be granted yet.
    req_valid = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);

    // Table-driven single-requester transactions.
    for (int i = 0; i < 14; i++) begin
      req_func[vecs[i].id] = vecs[i].func;
      if (vecs[i].id == 0) req_angle0 = vecs[i].angle;
      else req_angle1 = vecs[i].angle;
      applyStimulus(2'b01 << vecs[i].id, vecs[i].id, vecs[i].idx, vecs[i].err, vecs[i].data, 0, 1'b0);
    end

    // Response back-pressure with a request raised and withdrawn while busy.
    req_func[0] = 1'b0;
    req_angle0 = 32'd120;
    applyStimulus(2'b01, 0, 60, 1'b0, 64'hBFE0_0000_0000_0000, 5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("withdrawn no rsp", 64'(rsp_valid), 64'd0);
      checkOutput("withdrawn no lut", 64'(lut_en), 64'd0);
      @(negedge clk);
    end

    // Reset during WAIT after serving req0 (leaves rr_ptr pointing at req1).
    req_func[1] = 1'b1;
    req_angle1 = 32'd210;
    req_angle0 = 32'd0;
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkResetOutputs("mid reset");
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("aborted no rsp", 64'(rsp_valid), 64'd0);
    end

    // Simultaneous requests: rr_ptr restarts at req0 and then alternates.
    req_func = 2'b10;
    req_angle0 = 32'd0;
    req_angle1 = 32'd210;
    applyStimulus(2'b11, 0, 0, 1'b0, 64'h3FF0_0000_0000_0000, 0, 1'b0);
    applyStimulus(2'b00, 1, 60, 1'b0, 64'hBFE0_0000_0000_0000, 0, 1'b0);
    applyStimulus(2'b11, 0, 0, 1'b0, 64'h3FF0_0000_0000_0000, 0, 1'b0);
    applyStimulus(2'b00, 1, 60, 1'b0, 64'hBFE0_0000_0000_0000, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
